// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind the synchronous FIFO: issues reads, absorbs
// the registered FIFO output into a 2-entry skid buffer, streams it out.
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  drained_cnt,
   output logic                  underflow_err,
   input  logic                  clr_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [1:0]            occ, occ_nxt;
   logic                  inflight, inflight_nxt;
   logic [FIFO_WIDTH-1:0] buf0, buf1;
   logic [FIFO_WIDTH-1:0] buf0_nxt, buf1_nxt;
   logic                  pop, capture;
   logic [1:0]            level;
   logic                  settle;

   assign m_valid = (occ != 2'd0);
   assign m_data  = buf0;
   assign busy    = (state != IDLE);
   assign pop     = m_valid && m_ready;
   assign capture = inflight;

   // Occupancy after this edge, before counting a read issued now.
   assign level = 2'(occ + {1'b0, inflight} - {1'b0, pop});

   assign fifo_rd_en   = enable && !fifo_empty && (level < 2'd2);
   assign inflight_nxt = fifo_rd_en;
   assign occ_nxt      = 2'(occ + {1'b0, capture} - {1'b0, pop});

   always_comb begin
      buf0_nxt = buf0;
      buf1_nxt = buf1;
      case ({pop, capture})
         2'b01: begin
            if (occ == 2'd0) buf0_nxt = fifo_data_out;
            else             buf1_nxt = fifo_data_out;
         end
         2'b10: buf0_nxt = buf1;
         2'b11: begin
            if (occ == 2'd1) begin
               buf0_nxt = fifo_data_out;
            end else begin
               buf0_nxt = buf1;
               buf1_nxt = fifo_data_out;
            end
         end
         default: ;
      endcase
   end

   // Nothing buffered or in flight after this edge, and no reason to read.
   assign settle = (occ_nxt == 2'd0) && !inflight_nxt
                   && (fifo_empty || !enable);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (fifo_rd_en) state_nxt = RUN;
         end
         RUN: begin
            if (settle)       state_nxt = IDLE;
            else if (!enable) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (settle)      state_nxt = IDLE;
            else if (enable) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         occ      <= 2'd0;
         inflight <= 1'b0;
         buf0     <= '0;
         buf1     <= '0;
      end else begin
         state    <= state_nxt;
         occ      <= occ_nxt;
         inflight <= inflight_nxt;
         buf0     <= buf0_nxt;
         buf1     <= buf1_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drained_cnt   <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (pop && (drained_cnt != {CNT_WIDTH{1'b1}}))
            drained_cnt <= drained_cnt + 1'b1;
         if (fifo_underflow)
            underflow_err <= 1'b1;
         else if (clr_err)
            underflow_err <= 1'b0;
      end
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the team's synchronous FIFO.
- Issues rd_en into the FIFO and absorbs its registered (1-cycle) data_out into a 2-entry skid buffer.
- Presents the words on a valid/ready stream for the next consumer.
- Also counts delivered words and latches FIFO underflow as a sticky error.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the upstream FIFO.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = allowed to issue new FIFO reads.
- fifo_empty  in  1  FIFO empty flag (combinational from FIFO count).
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_underflow  in  1  FIFO underflow pulse.
- fifo_rd_en  out  1  read request to the FIFO.
- m_valid  out  1  stream word available.
- m_data  out  FIFO_WIDTH  stream word (skid buffer head).
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- busy  out  1  read in flight or buffer non-empty.
- drained_cnt  out  CNT_WIDTH  words delivered, saturating.
- underflow_err  out  1  sticky FIFO underflow seen.
- clr_err  in  1  clears underflow_err.

Behaviour:
- Reset values (asynchronous): fifo_rd_en=0, m_valid=0, m_data=0, busy=0, drained_cnt=0, underflow_err=0. Internally occ=0, inflight=0, FSM=IDLE.
- Internal state:
  - occ: 0..2 words held in the skid buffer.
  - inflight: 0..1, set the cycle after fifo_rd_en is asserted.
  - pop = m_valid && m_ready.
- Read issue is combinational: fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop) < 2.
  - Never assert rd_en while fifo_empty=1.
  - m_ready feeds fifo_rd_en combinationally; this path is intentional and gives full throughput.
- Capture: when inflight=1, fifo_data_out is written into the buffer tail on the same edge.
  - Capture and pop in the same cycle: occ unchanged, FIFO order preserved.
  - Occupancy can never exceed 2; assert in the bench.
- Output: m_valid = (occ != 0); m_data = head entry, registered.
  - Once asserted, m_valid and m_data hold stable until pop.
  - Head shifts from entry 1 to entry 0 on pop.
- Throughput: with the FIFO non-empty and m_ready=1, one word per cycle after a 2-cycle initial latency.
  - Cycle 0: rd_en.
  - Cycle 1: capture.
  - Cycle 2: m_valid. Counted from the first rd_en edge.
- FSM states:
  - IDLE: occ=0, inflight=0. Goes to RUN when fifo_rd_en asserts.
  - RUN: enable=1 with activity. Goes to DRAIN when enable falls while occ+inflight != 0. Goes to IDLE when occ+inflight reaches 0 and fifo_empty=1.
  - DRAIN: enable=0. No new reads; the in-flight word still lands and the buffer keeps presenting. Goes to IDLE when occ+inflight=0. Goes to RUN if enable returns.
  - busy = (FSM != IDLE).
- drained_cnt increments on every pop and saturates at all-ones (no wrap).
- underflow_err is set by fifo_underflow and cleared by clr_err. Set wins if both are high in the same cycle.
- Reset mid-operation: the buffer and in-flight word are discarded and no m_valid is emitted afterwards. The FIFO shares rst_n and resets together.
- enable toggling mid-burst drops and duplicates no words.

Test Plan:
- Reset, FIFO preloaded with 0x0001..0x0004, m_ready=1, enable=1 → m_data 0x0001..0x0004 on 4 consecutive cycles starting 2 cycles after the first rd_en; drained_cnt=4; busy falls after the last pop.
- 8 words preloaded, m_ready=0 → exactly 2 rd_en pulses; occ=2; m_data=first word held stable. Then m_ready=1 → remaining 6 words in order with no gap.
- Stream in progress, enable dropped with one read in flight → DRAIN state; the in-flight and buffered words are delivered; no further rd_en; then IDLE.
- FIFO forced to signal fifo_underflow=1 for one cycle → underflow_err=1 and stays 1. clr_err and fifo_underflow high in the same cycle → stays 1. clr_err alone → 0.
- CNT_WIDTH=4, 20 words streamed → drained_cnt stops at 15.
- rst_n asserted with occ=2 and inflight=1 → all outputs 0 immediately (asynchronously). After release, with the FIFO empty, m_valid stays 0.
